// File: rtl/ru_pkg.sv
// ru_pkg -- shared types for the queued data-memory request unit.
//   req_kind_t : kind of a queued request (read or write)
//   ru_state_t : request-issue FSM state
//   req_t      : one queue entry {kind, addr, wdata}
// The entry widths below set the width of the queue storage; the top-level
// ADDR_W/DATA_W ports are cast into and out of these fields.
package ru_pkg;

  localparam int RU_ADDR_W = 32;
  localparam int RU_DATA_W = 32;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_t;

  typedef enum logic {
    RU_IDLE = 1'b0,
    RU_BUSY = 1'b1
  } ru_state_t;

  typedef struct packed {
    req_kind_t              kind;
    logic [RU_ADDR_W-1:0]   addr;
    logic [RU_DATA_W-1:0]   wdata;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// req_fifo -- synchronous in-order FIFO of DEPTH entries of type T.
//   CLK, RST : clock, synchronous active-high reset (clears pointers/count)
//   push     : write wdata; ignored when full unless a pop happens the same cycle
//   pop      : drop the head entry; ignored when empty
//   wdata    : entry to write
//   rdata    : head entry (valid when !empty)
//   empty    : no entries held
//   count    : number of entries held, 0..DEPTH
module req_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           full;
  logic           push_en;
  logic           pop_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // A full queue still accepts a push in the cycle its head is popped,
  // so a completing request frees its slot for the incoming one.
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_ff @(posedge CLK) begin
    if (push_en) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) wptr <= wptr + 1'b1;
      if (pop_en)  rptr <= rptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_request_unit.sv
// mem_request_unit -- queued data-memory request unit between the pipeline
// control unit and the dcache port. Requests are queued in order and driven
// to memory one at a time, each held until dhit.
//   CLK, RST              : clock, synchronous active-high reset
//   ihit                  : qualifies ctr_dREN / ctr_dWEN
//   ctr_dREN, ctr_dWEN    : load / store request (write wins if both)
//   ctr_addr, ctr_wdata   : request address and store data
//   dhit, dmemload        : memory completion and load data
//   imemREN               : instruction read enable (!stall)
//   dmemREN, dmemWEN      : registered read / write enable to memory
//   dmemaddr, dmemstore   : registered address / store data to memory
//   ld_valid, ld_data     : one-cycle pulse with completed load data
//   stall                 : queue full
//   timeout               : sticky; head request waited TIMEOUT cycles
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  RU_IDLE | nothing presented to memory; issues the queue head if any
//  RU_BUSY | head presented on dmem*; waiting for dhit, watchdog running
module mem_request_unit
  import ru_pkg::*;
#(
  parameter int ADDR_W  = RU_ADDR_W,
  parameter int DATA_W  = RU_DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              ctr_dREN,
  input  logic              ctr_dWEN,
  input  logic [ADDR_W-1:0] ctr_addr,
  input  logic [DATA_W-1:0] ctr_wdata,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic              timeout
);

  localparam int AW   = $clog2(DEPTH);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  ru_state_t      state_q;
  ru_state_t      state_d;
  logic           issue;
  logic           retire;

  req_t           q_in;
  req_t           q_head;
  logic           q_push;
  logic           q_empty;
  logic [AW:0]    q_count;

  logic [WD_W-1:0] wd_cnt;

  assign q_push     = ihit & (ctr_dREN | ctr_dWEN);
  assign q_in.kind  = ctr_dWEN ? REQ_WRITE : REQ_READ;
  assign q_in.addr  = RU_ADDR_W'(ctr_addr);
  assign q_in.wdata = RU_DATA_W'(ctr_wdata);

  assign stall   = (q_count == (AW+1)'(DEPTH));
  assign imemREN = ~stall;

  req_fifo #(
    .T     (req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (q_push),
    .pop   (retire),
    .wdata (q_in),
    .rdata (q_head),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= RU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      RU_IDLE: begin
        if (!q_empty) begin
          issue   = 1'b1;
          state_d = RU_BUSY;
        end
      end
      RU_BUSY: begin
        if (dhit) begin
          retire  = 1'b1;
          state_d = RU_IDLE;
        end
      end
      default: state_d = RU_IDLE;
    endcase
  end

  // Output registers and watchdog. The watchdog is a down-counter loaded
  // on issue; the cycle it would reach zero is the TIMEOUT-th BUSY cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      ld_valid  <= 1'b0;
      ld_data   <= '0;
      timeout   <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      ld_valid <= 1'b0;
      if (issue) begin
        dmemaddr  <= ADDR_W'(q_head.addr);
        dmemstore <= DATA_W'(q_head.wdata);
        dmemREN   <= (q_head.kind == REQ_READ);
        dmemWEN   <= (q_head.kind == REQ_WRITE);
        wd_cnt    <= WD_W'(TIMEOUT);
      end else if (retire) begin
        dmemREN <= 1'b0;
        dmemWEN <= 1'b0;
        wd_cnt  <= '0;
        // dmemREN still reflects the kind of the request being retired.
        if (dmemREN) begin
          ld_valid <= 1'b1;
          ld_data  <= dmemload;
        end
      end else if (state_q == RU_BUSY && wd_cnt != '0) begin
        wd_cnt <= wd_cnt - 1'b1;
        if (wd_cnt == WD_W'(1)) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
module tb_mem_request_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ihit = 1'b0;
  logic          ctr_dREN = 1'b0;
  logic          ctr_dWEN = 1'b0;
  logic [AW-1:0] ctr_addr = '0;
  logic [DW-1:0] ctr_wdata = '0;
  logic          dhit = 1'b0;
  logic [DW-1:0] dmemload = '0;
  logic          imemREN;
  logic          dmemREN;
  logic          dmemWEN;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          stall;
  logic          timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t          exp_req[$];
  logic [DW-1:0] exp_ld[$];
  logic          mon_en = 1'b0;
  logic          prev_act = 1'b0;

  mem_request_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ihit      (ihit),
    .ctr_dREN  (ctr_dREN),
    .ctr_dWEN  (ctr_dWEN),
    .ctr_addr  (ctr_addr),
    .ctr_wdata (ctr_wdata),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .imemREN   (imemREN),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .stall     (stall),
    .timeout   (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Drive one request for one cycle; accept says whether the unit must take it.
  task automatic push(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic accept);
    exp_t e;
    ihit = 1'b1; ctr_dREN = rd; ctr_dWEN = wr; ctr_addr = a; ctr_wdata = d;
    if (accept) begin
      e.wr = wr; e.addr = a; e.wdata = d;
      exp_req.push_back(e);
    end
    cyc();
    ihit = 1'b0; ctr_dREN = 1'b0; ctr_dWEN = 1'b0;
  endtask

  // Wait for a presented request, then complete it with one dhit cycle.
  task automatic complete(input logic [DW-1:0] d);
    for (int i = 0; i < 20 && !(dmemREN | dmemWEN); i++) cyc();
    if (!(dmemREN | dmemWEN)) begin
      chk("wait_active", 64'(dmemREN | dmemWEN), 64'd1);
      return;
    end
    dhit = 1'b1; dmemload = d;
    if (dmemREN) exp_ld.push_back(d);
    cyc();
    dhit = 1'b0;
  endtask

  // Scoreboard monitor: every new presentation and every ld_valid pulse
  // is matched against the next expected entry.
  always @(negedge CLK) begin
    logic act;
    exp_t e;
    logic [DW-1:0] ld;
    if (mon_en) begin
      act = dmemREN | dmemWEN;
      if (act && !prev_act) begin
        if (exp_req.size() == 0) begin
          chk("issue_unexpected", 64'(exp_req.size()), 64'd1);
        end else begin
          e = exp_req.pop_front();
          chk("issue_kind", 64'({dmemWEN, dmemREN}), e.wr ? 64'd2 : 64'd1);
          chk("issue_addr", 64'(dmemaddr), 64'(e.addr));
          if (e.wr) chk("issue_wdata", 64'(dmemstore), 64'(e.wdata));
        end
      end
      if (ld_valid) begin
        if (exp_ld.size() == 0) begin
          chk("ld_unexpected", 64'(exp_ld.size()), 64'd1);
        end else begin
          ld = exp_ld.pop_front();
          chk("ld_data", 64'(ld_data), 64'(ld));
        end
      end
      prev_act = act;
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset
    cyc(); cyc();
    RST = 1'b0;
    chk("rst_dmemREN",  64'(dmemREN), 64'd0);
    chk("rst_dmemWEN",  64'(dmemWEN), 64'd0);
    chk("rst_dmemaddr", 64'(dmemaddr), 64'd0);
    chk("rst_ld_valid", 64'(ld_valid), 64'd0);
    chk("rst_stall",    64'(stall), 64'd0);
    chk("rst_imemREN",  64'(imemREN), 64'd1);
    chk("rst_timeout",  64'(timeout), 64'd0);
    mon_en = 1'b1;

    // 1. single load, 1-cycle issue latency, dhit three cycles later
    push(1'b1, 1'b0, 32'h100, 32'h0, 1'b1);
    chk("t1_not_yet", 64'(dmemREN), 64'd0);
    cyc();
    chk("t1_ren", 64'(dmemREN), 64'd1);
    chk("t1_addr", 64'(dmemaddr), 64'h100);
    cyc(); cyc();
    chk("t1_hold", 64'(dmemREN), 64'd1);
    dhit = 1'b1; dmemload = 32'hDEADBEEF; exp_ld.push_back(32'hDEADBEEF);
    cyc();
    dhit = 1'b0;
    chk("t1_ld_valid", 64'(ld_valid), 64'd1);
    chk("t1_ld_data", 64'(ld_data), 64'hDEADBEEF);
    chk("t1_ren_off", 64'(dmemREN), 64'd0);
    cyc();
    chk("t1_ld_pulse", 64'(ld_valid), 64'd0);

    // 2. fill with stores (last with both enables: write wins), overflow push ignored
    for (int i = 0; i < 4; i++)
      push(i == 3, 1'b1, 32'h200 + 32'(i) * 4, 32'h5000 + 32'(i), 1'b1);
    chk("t2_stall", 64'(stall), 64'd1);
    chk("t2_imemREN", 64'(imemREN), 64'd0);
    chk("t2_wen", 64'(dmemWEN), 64'd1);
    push(1'b0, 1'b1, 32'h2FC, 32'hBAD, 1'b0);
    chk("t2_still_stall", 64'(stall), 64'd1);
    complete(32'h0);
    chk("t2_unstall", 64'(stall), 64'd0);
    chk("t2_imemREN_back", 64'(imemREN), 64'd1);
    for (int i = 0; i < 3; i++) complete(32'h0);
    chk("t2_drained", 64'(exp_req.size()), 64'd0);

    // 3. mixed order with dhit on every 2nd cycle
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(i % 2 == 0, i % 2 == 1, 32'(i) * 4, 32'h7700 + 32'(i), 1'b1);
          cyc(); cyc(); cyc();
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          if (c % 2 == 1) begin
            dhit = 1'b1; dmemload = 32'hA000_0000 + 32'(c);
            if (dmemREN) exp_ld.push_back(dmemload);
          end else begin
            dhit = 1'b0;
          end
          cyc();
        end
        dhit = 1'b0;
      end
    join
    chk("t3_all_issued", 64'(exp_req.size()), 64'd0);
    chk("t3_all_loads", 64'(exp_ld.size()), 64'd0);

    // 4. push and pop in the same cycle while full
    push(1'b0, 1'b1, 32'h300, 32'h3300, 1'b1);
    push(1'b1, 1'b0, 32'h304, 32'h0, 1'b1);
    push(1'b0, 1'b1, 32'h308, 32'h3308, 1'b1);
    push(1'b1, 1'b0, 32'h30C, 32'h0, 1'b1);
    chk("t4_full", 64'(stall), 64'd1);
    chk("t4_head_active", 64'(dmemWEN), 64'd1);
    dhit = 1'b1; dmemload = 32'h0;
    push(1'b1, 1'b0, 32'h400, 32'h0, 1'b1);
    dhit = 1'b0;
    chk("t4_still_full", 64'(stall), 64'd1);
    for (int i = 0; i < 4; i++) complete(32'hB0 + 32'(i));
    chk("t4_drained", 64'(exp_req.size()), 64'd0);
    chk("t4_empty", 64'(stall), 64'd0);

    // 5. watchdog
    chk("t5_no_timeout", 64'(timeout), 64'd0);
    push(1'b1, 1'b0, 32'h500, 32'h0, 1'b1);
    cyc();
    chk("t5_busy", 64'(dmemREN), 64'd1);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("t5_early", 64'(timeout), 64'd0);
    end
    cyc();
    chk("t5_timeout", 64'(timeout), 64'd1);
    complete(32'h55);
    cyc();
    chk("t5_sticky", 64'(timeout), 64'd1);

    // 6. reset while busy with three queued
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 32'h600 + 32'(i) * 4, 32'h0, 1'b1);
    cyc();
    chk("t6_busy", 64'(dmemREN), 64'd1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    exp_req.delete();
    exp_ld.delete();
    chk("t6_ren", 64'(dmemREN), 64'd0);
    chk("t6_wen", 64'(dmemWEN), 64'd0);
    chk("t6_addr", 64'(dmemaddr), 64'd0);
    chk("t6_store", 64'(dmemstore), 64'd0);
    chk("t6_ld_data", 64'(ld_data), 64'd0);
    chk("t6_timeout", 64'(timeout), 64'd0);
    chk("t6_stall", 64'(stall), 64'd0);
    cyc(); cyc();
    chk("t6_queue_empty", 64'(dmemREN | dmemWEN), 64'd0);
    dhit = 1'b1; dmemload = 32'h1234;
    cyc();
    dhit = 1'b0;
    chk("t6_no_ld", 64'(ld_valid), 64'd0);
    cyc();
    chk("t6_no_issue", 64'(dmemREN | dmemWEN), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
